// File: rtl/ex_muldiv_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_if
// Request/response bundle for the iterative multiply/divide unit.
//   Request  : valid_i, ready_o, op_i, src1_i, src2_i, tag_i
//   Response : valid_o, ready_i, result_o, tag_o
// Signal names are seen from the unit's side: the slave modport is the unit,
// the master modport is whoever issues requests and consumes results.
// ---------------------------------------------------------------------------
interface ex_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();

  logic             valid_i;
  logic             ready_o;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic [TAG_W-1:0] tag_o;

  modport slave (
    input  valid_i, op_i, src1_i, src2_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o
  );

  modport master (
    output valid_i, op_i, src1_i, src2_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o
  );

endinterface

// File: rtl/ex_muldiv_iter.sv
// ---------------------------------------------------------------------------
// ex_muldiv_iter
// Multi-cycle radix-2 multiply/divide unit for the execute stage.
// Ops: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved (0).
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-high
//   flush_i : kill any in-flight operation (wins over everything but rst)
//   bus     : ex_muldiv_if.slave request/response handshake
// Flow: IDLE -accept-> CALC (WIDTH steps) -> FIX (sign fixup) -> DONE.
// Divide-by-zero, signed overflow and op 7 skip straight from IDLE to DONE.
// ---------------------------------------------------------------------------
module ex_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  ex_muldiv_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;
  localparam logic [2:0] OP_MODU  = 3'd6;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e             state_q,   state_d;
  logic [2:0]         op_q,      op_d;
  logic [TAG_W-1:0]   tag_q,     tag_d;
  logic               neg_q,     neg_d;      // quotient / product sign flip
  logic               rem_neg_q, rem_neg_d;  // remainder follows dividend sign
  logic [WIDTH-1:0]   addend_q,  addend_d;   // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] acc_q,     acc_d;      // {hi, lo} working accumulator
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   result_q,  result_d;

  // Request decode (only meaningful at accept)
  logic             in_signed_s;
  logic             in_is_mul_s;
  logic             in_is_div_s;
  logic             s1_neg_s;
  logic             s2_neg_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic             div0_s;
  logic             ovf_s;
  logic             special_s;
  logic [WIDTH-1:0] special_res_s;

  // Iteration step datapath
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_trial_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic               is_mul_q_s;

  // Fixup datapath
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   fix_res_s;

  // Decode the incoming request: signedness, magnitudes and early-out cases
  always_comb begin
    in_signed_s   = (bus.op_i == OP_MUL) || (bus.op_i == OP_MULH) ||
                    (bus.op_i == OP_DIV) || (bus.op_i == OP_MOD);
    in_is_mul_s   = (bus.op_i == OP_MUL) || (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHU);
    in_is_div_s   = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU) ||
                    (bus.op_i == OP_MOD) || (bus.op_i == OP_MODU);
    s1_neg_s      = in_signed_s && bus.src1_i[WIDTH-1];
    s2_neg_s      = in_signed_s && bus.src2_i[WIDTH-1];
    // abs(MIN) wraps to MIN, which is the correct unsigned magnitude
    a_abs_s       = s1_neg_s ? (~bus.src1_i + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src1_i;
    b_abs_s       = s2_neg_s ? (~bus.src2_i + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src2_i;
    div0_s        = in_is_div_s && (bus.src2_i == {WIDTH{1'b0}});
    ovf_s         = ((bus.op_i == OP_DIV) || (bus.op_i == OP_MOD)) &&
                    (bus.src1_i == MIN_VAL) && (bus.src2_i == {WIDTH{1'b1}});
    special_s     = (bus.op_i == 3'd7) || div0_s || ovf_s;
    if (bus.op_i == 3'd7) begin
      special_res_s = {WIDTH{1'b0}};
    end else if (div0_s) begin
      special_res_s = ((bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU)) ?
                      {WIDTH{1'b1}} : bus.src1_i;
    end else if (ovf_s) begin
      special_res_s = (bus.op_i == OP_DIV) ? MIN_VAL : {WIDTH{1'b0}};
    end else begin
      special_res_s = {WIDTH{1'b0}};
    end
  end

  // One shift-add multiply step and one restoring divide step per cycle
  always_comb begin
    is_mul_q_s  = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
    // multiplier sits in acc lo and is consumed LSB first while the product grows in hi
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc_q[0] ? addend_q : {WIDTH{1'b0}})};
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    // partial remainder in hi, dividend shifts out of lo while quotient bits shift in
    div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_s    = div_trial_s >= {1'b0, addend_q};
    // when trial >= divisor the difference is below the divisor, so WIDTH bits suffice
    div_diff_s  = div_trial_s[WIDTH-1:0] - addend_q;
    if (div_ge_s) begin
      div_next_s = {div_diff_s, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup and result selection
  always_comb begin
    prod_fix_s = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
    quo_fix_s  = neg_q ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q[WIDTH-1:0];
    rem_fix_s  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                           : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                fix_res_s = prod_fix_s[WIDTH-1:0];
      OP_MULH, OP_MULHU:     fix_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:       fix_res_s = quo_fix_s;
      OP_MOD, OP_MODU:       fix_res_s = rem_fix_s;
      default:               fix_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    addend_d  = addend_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    if (flush_i) begin
      // everything else holds so a killed op never disturbs result_o/tag_o
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.valid_i) begin
            op_d      = bus.op_i;
            tag_d     = bus.tag_i;
            neg_d     = s1_neg_s ^ s2_neg_s;
            rem_neg_d = s1_neg_s;
            cnt_d     = CNT_W'(WIDTH-1);
            if (special_s) begin
              result_d = special_res_s;
              state_d  = ST_DONE;
            end else if (in_is_mul_s) begin
              addend_d = a_abs_s;
              acc_d    = {{WIDTH{1'b0}}, b_abs_s};
              state_d  = ST_CALC;
            end else begin
              addend_d = b_abs_s;
              acc_d    = {{WIDTH{1'b0}}, a_abs_s};
              state_d  = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_d = is_mul_q_s ? mul_next_s : div_next_s;
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          result_d = fix_res_s;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (bus.ready_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'd0;
      tag_q     <= {TAG_W{1'b0}};
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      addend_q  <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      result_q  <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      addend_q  <= addend_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready_o  = (state_q == ST_IDLE);
  assign bus.valid_o  = (state_q == ST_DONE);
  assign bus.result_o = result_q;
  assign bus.tag_o    = tag_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Self-checking bench for ex_muldiv_iter (WIDTH=32, TAG_W=5).
module tb_ex_muldiv_iter;

  logic clk;
  logic rst;
  logic flush_i;
  int   checks;
  int   errors;

  ex_muldiv_if #(.WIDTH(32), .TAG_W(5)) bus ();

  ex_muldiv_iter #(.WIDTH(32), .TAG_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Early-out cases: reserved op, divide by zero, signed overflow
  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_div;
    is_div = (op >= 3'd3) && (op <= 3'd6);
    if (op == 3'd7) return 1'b1;
    if (is_div && b == 32'd0) return 1'b1;
    if ((op == 3'd3 || op == 3'd5) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Reference result from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sr = sa * sb; p = sr; return p[31:0]; end
      3'd1: begin sr = sa * sb; p = sr; return p[63:32]; end
      3'd2: begin ur = ua * ub; p = ur; return p[63:32]; end
      3'd3: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sr = sa / sb; p = sr; return p[31:0];
      end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        ur = ua / ub; p = ur; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb; p = sr; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        ur = ua % ub; p = ur; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Wait (bounded) for ready_o, then present one request for one edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg);
    int w;
    w = 0;
    while (!bus.ready_o && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("ready_before_issue", bus.ready_o, 1);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    bus.tag_i   = tg;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    // scramble inputs to show they are only sampled at accept
    bus.op_i    = 3'($urandom);
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    bus.tag_i   = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input int hold,
                        input logic [31:0] exp_r, input int exp_lat);
    int lat;
    issue(op, a, b, tg);
    lat = 1;
    while (!bus.valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("result", bus.result_o, exp_r);
    check_eq("tag", bus.tag_o, tg);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", bus.valid_o, 1);
      check_eq("hold_result", bus.result_o, exp_r);
      check_eq("hold_tag", bus.tag_o, tg);
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    check_eq("valid_after_hs", bus.valid_o, 0);
    check_eq("ready_after_hs", bus.ready_o, 1);
  endtask

  initial begin
    int          vcount;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tg;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    flush_i     = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.src1_i  = 32'd0;
    bus.src2_i  = 32'd0;
    bus.tag_i   = 5'd0;
    #3;
    check_eq("rst_ready", bus.ready_o, 1);
    check_eq("rst_valid", bus.valid_o, 0);
    check_eq("rst_result", bus.result_o, 0);
    check_eq("rst_tag", bus.tag_o, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived results
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 5'h0A, 0, 32'hFFFF_FFEB, 34);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'h01, 0, 32'h4000_0000, 34);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 0, 32'hFFFF_FFFE, 34);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 5'h03, 0, 32'hFFFF_FFFD, 34);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'h04, 0, 32'hFFFF_FFFF, 34);
    run_op(3'd4, 32'd100, 32'd7, 5'h05, 0, 32'd14, 34);
    run_op(3'd6, 32'd100, 32'd7, 5'h06, 0, 32'd2, 34);
    run_op(3'd3, 32'd5, 32'd0, 5'h07, 0, 32'hFFFF_FFFF, 1);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'h08, 0, 32'd0, 1);
    run_op(3'd7, 32'd9, 32'd9, 5'h09, 0, 32'd0, 1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'h0B, 0, 32'hFFFF_FFF9, 1);

    // Flush in CALC cycle 10 with a simultaneous (ignored) request
    issue(3'd4, 32'd1000, 32'd3, 5'h11);
    repeat (9) begin @(posedge clk); #1; end
    flush_i     = 1'b1;
    bus.valid_i = 1'b1;
    bus.op_i    = 3'd7;
    @(posedge clk); #1;
    flush_i     = 1'b0;
    bus.valid_i = 1'b0;
    check_eq("flush_ready", bus.ready_o, 1);
    check_eq("flush_valid", bus.valid_o, 0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o) vcount++;
    end
    check_eq("flush_no_valid", vcount, 0);
    run_op(3'd0, 32'd6, 32'd7, 5'h12, 0, 32'd42, 34);

    // Back-pressure: hold ready_i low for 5 cycles in DONE
    run_op(3'd3, 32'd77, 32'hFFFF_FFF5, 5'h13, 5, 32'hFFFF_FFF9, 34);

    // Flush during the DONE handshake discards the result
    issue(3'd0, 32'd3, 32'd3, 5'h14);
    repeat (40) begin
      if (!bus.valid_o) begin @(posedge clk); #1; end
    end
    check_eq("done_before_flush", bus.valid_o, 1);
    flush_i     = 1'b1;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i     = 1'b0;
    bus.ready_i = 1'b0;
    check_eq("done_flush_valid", bus.valid_o, 0);
    check_eq("done_flush_ready", bus.ready_o, 1);

    // Asynchronous reset in the middle of CALC
    issue(3'd0, 32'd123, 32'd456, 5'h15);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ready", bus.ready_o, 1);
    check_eq("arst_valid", bus.valid_o, 0);
    check_eq("arst_result", bus.result_o, 0);
    check_eq("arst_tag", bus.tag_o, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Randomized ops against the reference model, biased toward corner operands
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000;
        3:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      tg = 5'($urandom);
      run_op(op, a, b, tg, $urandom_range(0, 3), model(op, a, b), is_special(op, a, b) ? 1 : 34);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
